// File: rtl/keccak_pkg.sv
// ============================================================================
//  Module   : keccak_pkg
//  Brief    : Shared Keccak squeeze constants, dump-stage FSM state type and
//             the helper that maps an operation mode to its last word index.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package keccak_pkg;

    localparam int WORD_WIDTH     = 64;
    localparam int RATE_SHAKE128  = 1344;
    localparam int WORDS_SHAKE128 = 21;
    localparam int WORDS_SHAKE256 = 17;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } dump_state_e;

    // Reserved mode codes fall back to the shorter SHAKE256 block.
    function automatic logic [4:0] last_word_idx(input logic [1:0] mode);
        return (mode == MODE_SHAKE128) ? 5'(WORDS_SHAKE128 - 1)
                                       : 5'(WORDS_SHAKE256 - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dump_fsm.sv
// ============================================================================
//  Module   : dump_fsm
//  Brief    : Control for the squeeze dump stage: IDLE/STREAM state, output
//             handshake, word index and remaining-bits job counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dump_fsm
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        buffer_we_i,
    input  logic [1:0]  mode_i,
    input  logic [31:0] output_size_i,
    input  logic        dout_ready_i,
    output logic        buffer_available_o,
    output logic        dout_valid_o,
    output logic        dout_last_o,
    output logic [4:0]  word_idx_o,
    output logic [31:0] remaining_o
);

    dump_state_e state_q, state_d;
    logic [4:0]  word_idx_q, word_idx_d;
    logic [4:0]  last_idx_q, last_idx_d;
    logic [31:0] remaining_q, remaining_d;
    logic        job_active_q, job_active_d;
    logic        fire;
    logic [31:0] step;

    assign buffer_available_o = (state_q == ST_IDLE);
    assign dout_valid_o       = (state_q == ST_STREAM) && (remaining_q != 32'd0);
    assign dout_last_o        = dout_valid_o && (remaining_q <= 32'd64);
    assign fire               = dout_valid_o && dout_ready_i;
    assign step               = (remaining_q > 32'd64) ? 32'd64 : remaining_q;
    assign word_idx_o         = word_idx_q;
    assign remaining_o        = remaining_q;

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        last_idx_d   = last_idx_q;
        remaining_d  = remaining_q;
        job_active_d = job_active_q;
        case (state_q)
            ST_IDLE: begin
                if (buffer_we_i) begin
                    state_d    = ST_STREAM;
                    word_idx_d = 5'd0;
                    last_idx_d = last_word_idx(mode_i);
                    // A continuing job keeps its count across blocks.
                    if (!job_active_q) begin
                        remaining_d  = output_size_i;
                        job_active_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (remaining_q == 32'd0) begin
                    state_d      = ST_IDLE;
                    job_active_d = 1'b0;
                    word_idx_d   = 5'd0;
                end else if (fire) begin
                    remaining_d = remaining_q - step;
                    if (dout_last_o) begin
                        state_d      = ST_IDLE;
                        job_active_d = 1'b0;
                        word_idx_d   = 5'd0;
                    end else if (word_idx_q == last_idx_q) begin
                        state_d    = ST_IDLE;
                        word_idx_d = 5'd0;
                    end else begin
                        word_idx_d = word_idx_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            word_idx_q   <= 5'd0;
            last_idx_q   <= 5'd0;
            remaining_q  <= 32'd0;
            job_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            last_idx_q   <= last_idx_d;
            remaining_q  <= remaining_d;
            job_active_q <= job_active_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dump_stage.sv
// ============================================================================
//  Module   : dump_stage
//  Brief    : Streams a squeezed Keccak rate block out as 64-bit words,
//             truncated to the requested output length.
//             Optional macro DUMP_STAGE_KEEP_EN adds the dout_keep byte mask.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dump_stage
    import keccak_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RATE_SHAKE128-1:0] rate_input,
    input  logic                     buffer_we,
    input  logic [1:0]               operation_mode_in,
    input  logic [31:0]              output_size,
    output logic                     buffer_available,
    output logic [WORD_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last
`ifdef DUMP_STAGE_KEEP_EN
    ,
    output logic [7:0]               dout_keep
`endif
);

    logic [RATE_SHAKE128-1:0] rate_q;
    logic [4:0]               word_idx;
    logic [31:0]              remaining;
    logic [WORD_WIDTH-1:0]    word_sel;
    logic [WORD_WIDTH-1:0]    tail_mask;

    dump_fsm u_fsm (
        .clk                (clk),
        .rst                (rst),
        .buffer_we_i        (buffer_we),
        .mode_i             (operation_mode_in),
        .output_size_i      (output_size),
        .dout_ready_i       (dout_ready),
        .buffer_available_o (buffer_available),
        .dout_valid_o       (dout_valid),
        .dout_last_o        (dout_last),
        .word_idx_o         (word_idx),
        .remaining_o        (remaining)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_q <= '0;
        end else if (buffer_we && buffer_available) begin
            rate_q <= rate_input;
        end
    end

    assign word_sel  = rate_q[{word_idx, 6'd0} +: WORD_WIDTH];
    assign tail_mask = (remaining >= 32'd64) ? '1
                     : ((64'd1 << remaining[5:0]) - 64'd1);
    // Outputs are forced to zero when idle so the reset value needs no extra flop.
    assign dout      = dout_valid ? (word_sel & tail_mask) : '0;

`ifdef DUMP_STAGE_KEEP_EN
    logic [6:0] tail_bits_up;
    logic [7:0] keep_tail;

    assign tail_bits_up = {1'b0, remaining[5:0]} + 7'd7;
    assign keep_tail    = 8'((9'd1 << tail_bits_up[6:3]) - 9'd1);
    assign dout_keep    = !dout_valid ? 8'h00
                        : (remaining >= 32'd64) ? 8'hFF : keep_tail;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dump_stage.sv
// ============================================================================
//  Module   : tb_dump_stage
//  Brief    : Self-checking bench for dump_stage with a word-queue model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dump_stage;
    import keccak_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [RATE_SHAKE128-1:0] rate_input = '0;
    logic                     buffer_we = 1'b0;
    logic [1:0]               operation_mode_in = 2'b00;
    logic [31:0]              output_size = 32'd0;
    logic                     buffer_available;
    logic [63:0]              dout;
    logic                     dout_valid;
    logic                     dout_ready = 1'b1;
    logic                     dout_last;
`ifdef DUMP_STAGE_KEEP_EN
    logic [7:0]               dout_keep;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          toggle_ready = 1'b0;
    logic [63:0] exp_dout [0:255];
    logic        exp_last [0:255];
    logic [7:0]  exp_keep [0:255];
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          hs_total = 0;
    bit          after_last = 1'b0;
    logic [63:0] last_dout = '0;
    logic [7:0]  last_keep = '0;
    logic [7:0]  prev_keep = '0;
    int          job_rem = 0;
    bit          job_on  = 1'b0;
    int          base;

    always #5 clk = ~clk;

    dump_stage dut (
        .clk               (clk),
        .rst               (rst),
        .rate_input        (rate_input),
        .buffer_we         (buffer_we),
        .operation_mode_in (operation_mode_in),
        .output_size       (output_size),
        .buffer_available  (buffer_available),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout_last         (dout_last)
`ifdef DUMP_STAGE_KEEP_EN
        ,
        .dout_keep         (dout_keep)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] wd(input int blk, input int i);
        return {16'hC3A5 ^ 16'(blk), 16'(i) * 16'h1111, 32'h9E3779B9 ^ 32'(blk * 37 + i)};
    endfunction

    // Model: the words a block contributes, given the job's remaining length.
    task automatic model_block(input logic [1:0] m, input int osz, input int blk);
        int n;
        n = (m == 2'b00) ? 21 : 17;
        if (!job_on) begin
            job_rem = osz;
            job_on  = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            if (job_rem == 0) break;
            exp_dout[exp_wr] = wd(blk, i) & ((job_rem >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                             : ((64'd1 << job_rem) - 64'd1));
            exp_keep[exp_wr] = (job_rem >= 64) ? 8'hFF
                             : 8'((9'd1 << ((job_rem + 7) / 8)) - 9'd1);
            exp_last[exp_wr] = (job_rem <= 64);
            exp_wr++;
            if (job_rem <= 64) begin
                job_rem = 0;
                break;
            end
            job_rem -= 64;
        end
        if (job_rem == 0) job_on = 1'b0;
    endtask

    task automatic send_block(input logic [1:0] m, input int osz, input int blk);
        int t = 0;
        while (!buffer_available && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!buffer_available) chk("send_timeout", buffer_available, 1);
        for (int i = 0; i < 21; i++) rate_input[i*64 +: 64] = wd(blk, i);
        operation_mode_in = m;
        output_size       = 32'(osz);
        buffer_we         = 1'b1;
        model_block(m, osz, blk);
        @(posedge clk); #1;
        buffer_we = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (!(exp_rd == exp_wr && buffer_available) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) chk("drain_timeout", 64'(exp_wr - exp_rd), 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        dout_ready = toggle_ready ? ~dout_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_rd     = exp_wr;
            after_last = 1'b0;
        end else begin
            if (after_last) begin
                chk("avail_after_last", buffer_available, 1);
                after_last = 1'b0;
            end
            if (dout_valid) begin
                if (exp_rd == exp_wr) begin
                    chk("spurious_valid", dout_valid, 0);
                end else begin
                    chk("dout", dout, exp_dout[exp_rd]);
                    chk("dout_last", dout_last, exp_last[exp_rd]);
`ifdef DUMP_STAGE_KEEP_EN
                    chk("dout_keep", dout_keep, exp_keep[exp_rd]);
`endif
                    if (dout_ready) begin
                        last_dout = dout;
`ifdef DUMP_STAGE_KEEP_EN
                        prev_keep = last_keep;
                        last_keep = dout_keep;
`endif
                        if (dout_last) after_last = 1'b1;
                        exp_rd++;
                        hs_total++;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avail", buffer_available, 1);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // SHAKE128, 256 bits
        base = hs_total;
        send_block(2'b00, 256, 1);
        drain();
        chk("t1_words", 64'(hs_total - base), 4);
        chk("t1_final", last_dout, wd(1, 3));

        // SHAKE256, 1200 bits across two blocks; second size must be ignored
        base = hs_total;
        send_block(2'b01, 1200, 2);
        drain();
        chk("t2_blk1_words", 64'(hs_total - base), 17);
        send_block(2'b01, 64, 3);
        drain();
        chk("t2_words", 64'(hs_total - base), 19);
        chk("t2_final", last_dout, wd(3, 1) & 64'h0000_FFFF_FFFF_FFFF);

        // Backpressure, exactly one full SHAKE128 block
        toggle_ready = 1'b1;
        base = hs_total;
        send_block(2'b00, 1344, 4);
        drain();
        toggle_ready = 1'b0;
        chk("t3_words", 64'(hs_total - base), 21);
        chk("t3_final", last_dout, wd(4, 20));

        // buffer_we pulsed during STREAM is ignored
        base = hs_total;
        send_block(2'b01, 500, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 21; i++) rate_input[i*64 +: 64] = wd(99, i);
        operation_mode_in = 2'b00;
        output_size       = 32'd7;
        buffer_we         = 1'b1;
        @(posedge clk); #1;
        buffer_we = 1'b0;
        drain();
        chk("t4_words", 64'(hs_total - base), 8);
        chk("t4_final", last_dout, wd(5, 7) & 64'h000F_FFFF_FFFF_FFFF);

        // Zero-length job
        base = hs_total;
        send_block(2'b00, 0, 6);
        chk("t5_busy", buffer_available, 0);
        @(posedge clk); #1;
        chk("t5_idle_next", buffer_available, 1);
        chk("t5_words", 64'(hs_total - base), 0);

        // Reserved mode code gives 17 words, job continues into next block
        base = hs_total;
        send_block(2'b11, 1098, 7);
        drain();
        chk("t6_blk1_words", 64'(hs_total - base), 17);
        send_block(2'b00, 0, 8);
        drain();
        chk("t6_words", 64'(hs_total - base), 18);
        chk("t6_final", last_dout, wd(8, 0) & 64'h0000_0000_0000_03FF);

        // Reset while word 5 is presented
        base = hs_total;
        send_block(2'b00, 5000, 9);
        for (int t = 0; t < 100 && (hs_total - base) < 5; t++) begin
            @(posedge clk); #1;
        end
        chk("t7_reached_w5", 64'(hs_total - base), 5);
        rst = 1'b0;
        #1;
        chk("t7_valid", dout_valid, 0);
        chk("t7_avail", buffer_available, 1);
        chk("t7_last", dout_last, 0);
        chk("t7_dout", dout, 0);
        job_on  = 1'b0;
        job_rem = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        base = hs_total;
        send_block(2'b00, 128, 10);
        drain();
        chk("t7_words", 64'(hs_total - base), 2);
        chk("t7_final", last_dout, wd(10, 1));

        // 100-bit job: second word keeps 36 bits
        base = hs_total;
        send_block(2'b00, 100, 11);
        drain();
        chk("t8_words", 64'(hs_total - base), 2);
        chk("t8_final", last_dout, wd(11, 1) & 64'h0000_000F_FFFF_FFFF);
`ifdef DUMP_STAGE_KEEP_EN
        chk("t8_keep0", prev_keep, 8'hFF);
        chk("t8_keep1", last_keep, 8'h1F);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
